// File: rtl/video_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// video_pipeline_pkg
// Shared widths and types for the scaler-clock video pipeline.
//   HACTIVE_BITS / VACTIVE_BITS  : line / row coordinate widths
//   CHUNKNUM_BITS                : chunk index within a line
//   REQUEST_BITS                 : chunk request word (row + chunk number)
//   BITS_PER_PIXEL               : pixel word width
//   arb_state_e                  : state encoding of video_request_arbiter
// ---------------------------------------------------------------------------
package video_pipeline_pkg;

    localparam int HACTIVE_BITS   = 11;
    localparam int VACTIVE_BITS   = 11;
    localparam int CHUNKNUM_BITS  = 6;
    localparam int REQUEST_BITS   = VACTIVE_BITS + CHUNKNUM_BITS;
    localparam int BITS_PER_PIXEL = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        STREAM = 2'd2
    } arb_state_e;

endpackage

// File: rtl/video_rr_select_2.sv
// ---------------------------------------------------------------------------
// video_rr_select_2
// Combinational two-way picker.
//   last_grant : client served most recently
//   requests   : per-client "has a request" flags
//   valid      : at least one client is requesting
//   index      : selected client (meaningful only when valid)
// Build option: VIDEO_ARB_STRICT_PRIORITY_EN makes client 0 always win when it
// requests; otherwise the client after last_grant has priority.
// ---------------------------------------------------------------------------
module video_rr_select_2 (
    input  logic       last_grant,
    input  logic [1:0] requests,
    output logic       valid,
    output logic       index
);

    assign valid = |requests;

`ifdef VIDEO_ARB_STRICT_PRIORITY_EN
    // last_grant is still an input so the port list is build-independent.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign index             = ~requests[0];
`else
    logic preferred;
    assign preferred = ~last_grant;
    assign index     = requests[preferred] ? preferred : ~preferred;
`endif

endmodule

// File: rtl/video_request_arbiter.sv
// ---------------------------------------------------------------------------
// video_request_arbiter
// Shares one upstream pixel source between two client request/response FIFO
// pairs. A client request is popped, offered upstream as a one-entry FIFO, and
// exactly one chunk of (1<<CHUNK_BITS) response pixels is routed back to the
// client that issued it. One chunk is outstanding at a time.
// Ports:
//   scalerClock, reset                        clock / async active-high reset
//   clientRequestFifoEmpty/ReadData/ReadEnable per-client FWFT request FIFOs
//   clientResponseFifoFull/WriteEnable        per-client response FIFOs
//   clientResponseFifoWriteData               pixel broadcast to both clients
//   upstreamRequestFifo*                      request FIFO seen by the source
//   upstreamResponseFifo*                     response FIFO seen by the source
//   grant                                     client owning the source
//   busy                                      a chunk is being offered/streamed
// Build option: VIDEO_ARB_STRICT_PRIORITY_EN (see video_rr_select_2).
// ---------------------------------------------------------------------------
module video_request_arbiter #(
    parameter int CHUNK_BITS     = 5,
    parameter int REQUEST_BITS   = video_pipeline_pkg::REQUEST_BITS,
    parameter int BITS_PER_PIXEL = video_pipeline_pkg::BITS_PER_PIXEL
) (
    input  logic                      scalerClock,
    input  logic                      reset,
    input  logic [1:0]                clientRequestFifoEmpty,
    input  logic [2*REQUEST_BITS-1:0] clientRequestFifoReadData,
    output logic [1:0]                clientRequestFifoReadEnable,
    input  logic [1:0]                clientResponseFifoFull,
    output logic [1:0]                clientResponseFifoWriteEnable,
    output logic [BITS_PER_PIXEL-1:0] clientResponseFifoWriteData,
    input  logic                      upstreamRequestFifoReadEnable,
    output logic                      upstreamRequestFifoEmpty,
    output logic [REQUEST_BITS-1:0]   upstreamRequestFifoReadData,
    input  logic                      upstreamResponseFifoWriteEnable,
    output logic                      upstreamResponseFifoFull,
    input  logic [BITS_PER_PIXEL-1:0] upstreamResponseFifoWriteData,
    output logic                      grant,
    output logic                      busy
);

    import video_pipeline_pkg::*;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_OFFER  = OFFER;
    localparam logic [1:0] ST_STREAM = STREAM;

    localparam logic [CHUNK_BITS-1:0] LAST_PIXEL = '1;

    logic [1:0]              state_reg, state_next;
    logic                    last_grant_reg, last_grant_next;
    logic                    grant_reg, grant_next;
    logic [CHUNK_BITS-1:0]   pixel_count_reg, pixel_count_next;
    logic [REQUEST_BITS-1:0] held_request_reg, held_request_next;

    logic sel_valid;
    logic sel_index;
    logic in_idle, in_offer, in_stream;
    logic pop;
    logic grant_full;
    logic accept;

    video_rr_select_2 u_select (
        .last_grant (last_grant_reg),
        .requests   (~clientRequestFifoEmpty),
        .valid      (sel_valid),
        .index      (sel_index)
    );

    assign in_idle    = (state_reg == ST_IDLE);
    assign in_offer   = (state_reg == ST_OFFER);
    assign in_stream  = (state_reg == ST_STREAM);

    // Pop strobes are suppressed while reset is held so that every enable
    // reads 0 during reset even if a client FIFO is non-empty.
    assign pop        = in_idle & sel_valid & ~reset;
    assign grant_full = clientResponseFifoFull[grant_reg];
    assign accept     = in_stream & upstreamResponseFifoWriteEnable & ~grant_full;

    always_comb begin
        state_next        = state_reg;
        last_grant_next   = last_grant_reg;
        grant_next        = grant_reg;
        pixel_count_next  = pixel_count_reg;
        held_request_next = held_request_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next        = ST_OFFER;
                    grant_next        = sel_index;
                    held_request_next = sel_index
                        ? clientRequestFifoReadData[2*REQUEST_BITS-1:REQUEST_BITS]
                        : clientRequestFifoReadData[REQUEST_BITS-1:0];
                end
            end
            ST_OFFER: begin
                if (upstreamRequestFifoReadEnable) begin
                    state_next       = ST_STREAM;
                    pixel_count_next = '0;
                end
            end
            ST_STREAM: begin
                // Dropped (backpressured) writes do not advance the count.
                if (accept) begin
                    pixel_count_next = pixel_count_reg + 1'b1;
                    if (pixel_count_reg == LAST_PIXEL) begin
                        last_grant_next = grant_reg;
                        state_next      = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge scalerClock or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            last_grant_reg   <= 1'b1;
            grant_reg        <= 1'b0;
            pixel_count_reg  <= '0;
            held_request_reg <= '0;
        end else begin
            state_reg        <= state_next;
            last_grant_reg   <= last_grant_next;
            grant_reg        <= grant_next;
            pixel_count_reg  <= pixel_count_next;
            held_request_reg <= held_request_next;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_client
        assign clientRequestFifoReadEnable[gi]   = pop    & (sel_index == 1'(gi));
        assign clientResponseFifoWriteEnable[gi] = accept & (grant_reg == 1'(gi));
    end

    assign clientResponseFifoWriteData = upstreamResponseFifoWriteData;
    assign upstreamRequestFifoEmpty    = ~in_offer;
    assign upstreamRequestFifoReadData = held_request_reg;
    assign upstreamResponseFifoFull    = ~in_stream | grant_full;
    assign grant                       = grant_reg;
    assign busy                        = ~in_idle;

endmodule

// File: tb/tb_video_request_arbiter.sv
module tb_video_request_arbiter;

    localparam int RB    = 17;
    localparam int PB    = 16;
    localparam int CHUNK = 32;

    logic          scalerClock = 1'b0;
    logic          reset;
    logic [1:0]    req_empty, req_rd_en, rsp_full, rsp_wr_en;
    logic [2*RB-1:0] req_data;
    logic [PB-1:0] rsp_data, up_wdata;
    logic          up_rd_en, up_empty, up_we, up_full, grant, busy;
    logic [RB-1:0] up_rdata;

    video_request_arbiter #(.CHUNK_BITS(5), .REQUEST_BITS(RB), .BITS_PER_PIXEL(PB)) dut (
        .scalerClock                     (scalerClock),
        .reset                           (reset),
        .clientRequestFifoEmpty          (req_empty),
        .clientRequestFifoReadData       (req_data),
        .clientRequestFifoReadEnable     (req_rd_en),
        .clientResponseFifoFull          (rsp_full),
        .clientResponseFifoWriteEnable   (rsp_wr_en),
        .clientResponseFifoWriteData     (rsp_data),
        .upstreamRequestFifoReadEnable   (up_rd_en),
        .upstreamRequestFifoEmpty        (up_empty),
        .upstreamRequestFifoReadData     (up_rdata),
        .upstreamResponseFifoWriteEnable (up_we),
        .upstreamResponseFifoFull        (up_full),
        .upstreamResponseFifoWriteData   (up_wdata),
        .grant                           (grant),
        .busy                            (busy)
    );

    always #5 scalerClock = ~scalerClock;

    // Client request FIFOs (first-word-fall-through) modelled as queues.
    logic [RB-1:0] q0[$];
    logic [RB-1:0] q1[$];

    // Reference model: who owns the source, whether the request is still on
    // offer, how many pixels of the chunk have been delivered.
    int            owner;
    bit            offered;
    int            got;
    int            prev_winner;
    int            cur_grant;
    logic [RB-1:0] held;

    int total  = 0;
    int passes = 0;
    int fails  = 0;
    int wr_cnt[2];
    int pop_cnt[2];
    int grant_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit has_req(input int c);
        return (c == 0) ? (q0.size() != 0) : (q1.size() != 0);
    endfunction

    // Whom the arbiter should serve next, -1 if nobody is waiting.
    function automatic int pick();
`ifdef VIDEO_ARB_STRICT_PRIORITY_EN
        if (has_req(0)) return 0;
        if (has_req(1)) return 1;
        return -1;
`else
        int pref;
        pref = 1 - prev_winner;
        if (has_req(pref)) return pref;
        if (has_req(1 - pref)) return 1 - pref;
        return -1;
`endif
    endfunction

    task automatic model_reset();
        owner       = -1;
        offered     = 1'b0;
        got         = 0;
        prev_winner = 1;
        cur_grant   = 0;
        held        = '0;
    endtask

    task automatic reset_checks(input string tag);
        $display("reset check %s", tag);
        chk({tag, "_rd_en"}, 32'(req_rd_en), 32'd0);
        chk({tag, "_wr_en"}, 32'(rsp_wr_en), 32'd0);
        chk({tag, "_empty"}, 32'(up_empty), 32'd1);
        chk({tag, "_full"},  32'(up_full),  32'd1);
        chk({tag, "_grant"}, 32'(grant),    32'd0);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_rdata"}, 32'(up_rdata), 32'd0);
    endtask

    task automatic idle_inputs();
        req_empty = 2'b11;
        up_rd_en  = 1'b0;
        up_we     = 1'b0;
        rsp_full  = 2'b00;
    endtask

    task automatic do_reset(input string tag);
        @(negedge scalerClock);
        idle_inputs();
        reset = 1'b1;
        #1;
        reset_checks(tag);
        model_reset();
        @(negedge scalerClock);
        reset = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, check just after, then
    // advance the model at the rising edge.
    task automatic step(input int ure_pct, input int uwe_pct, input int full_pct, input bit hold_full1);
        int         w;
        bit         streaming;
        bit         acc;
        logic [1:0] exp_rd, exp_wr;
        @(negedge scalerClock);
        req_empty = {q1.size() == 0, q0.size() == 0};
        req_data  = {(q1.size() != 0) ? q1[0] : RB'($urandom),
                     (q0.size() != 0) ? q0[0] : RB'($urandom)};
        up_rd_en  = ($urandom_range(99) < ure_pct);
        up_we     = ($urandom_range(99) < uwe_pct);
        rsp_full[0] = ($urandom_range(99) < full_pct);
        rsp_full[1] = hold_full1 ? 1'b1 : ($urandom_range(99) < full_pct);
        streaming = (owner >= 0) && !offered;
        up_wdata  = streaming ? PB'(got) : PB'($urandom);
        #1;
        w      = (owner < 0) ? pick() : -1;
        exp_rd = 2'b00;
        if (w >= 0) exp_rd[w] = 1'b1;
        acc    = streaming && up_we && !rsp_full[owner];
        exp_wr = 2'b00;
        if (acc) exp_wr[owner] = 1'b1;

        chk("rd_en", 32'(req_rd_en), 32'(exp_rd));
        chk("wr_en", 32'(rsp_wr_en), 32'(exp_wr));
        chk("up_empty", 32'(up_empty), 32'(!((owner >= 0) && offered)));
        chk("up_full", 32'(up_full), streaming ? 32'(rsp_full[owner]) : 32'd1);
        chk("grant", 32'(grant), 32'(cur_grant));
        chk("busy", 32'(busy), 32'(owner >= 0));
        if (owner >= 0 && offered) chk("up_rdata", 32'(up_rdata), 32'(held));
        if (acc) chk("wdata", 32'(rsp_data), 32'(up_wdata));

        if (rsp_wr_en[0]) wr_cnt[0]++;
        if (rsp_wr_en[1]) wr_cnt[1]++;
        if (req_rd_en[0]) pop_cnt[0]++;
        if (req_rd_en[1]) pop_cnt[1]++;
        if (req_rd_en != 2'b00) grant_log.push_back(int'(req_rd_en[1]));

        @(posedge scalerClock);
        if (w >= 0) begin
            owner     = w;
            offered   = 1'b1;
            cur_grant = w;
            if (w == 0) begin held = q0[0]; void'(q0.pop_front()); end
            else        begin held = q1[0]; void'(q1.pop_front()); end
            $display("t=%0t grant client%0d request=%05h", $time, w, held);
        end else if (owner >= 0 && offered) begin
            if (up_rd_en) begin
                offered = 1'b0;
                got     = 0;
            end
        end else if (acc) begin
            got++;
            if (got == CHUNK) begin
                $display("t=%0t chunk done client%0d", $time, owner);
                prev_winner = owner;
                owner       = -1;
            end
        end
    endtask

    task automatic clear_counts();
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        pop_cnt[0] = 0; pop_cnt[1] = 0;
        grant_log.delete();
    endtask

    initial begin
        int n;
        int exp_order[6];

        reset    = 1'b1;
        req_data = '0;
        up_wdata = '0;
        idle_inputs();
        model_reset();
        clear_counts();
        #12;
        reset_checks("por");
        @(negedge scalerClock);
        reset = 1'b0;

        // Single client, one chunk, no backpressure.
        q0.push_back(17'h00123);
        repeat (45) step(100, 100, 0, 1'b0);
        chk("single_pops0", 32'(pop_cnt[0]), 32'd1);
        chk("single_wr0", 32'(wr_cnt[0]), 32'd32);
        chk("single_wr1", 32'(wr_cnt[1]), 32'd0);
        chk("single_busy", 32'(busy), 32'd0);

        // Contention: three requests queued per client.
        do_reset("pre_contention");
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(RB'($urandom));
            q1.push_back(RB'($urandom));
        end
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && owner < 0) && n < 400) begin
            step(100, 100, 0, 1'b0);
            n++;
        end
        chk("contention_done", 32'(n < 400), 32'd1);
`ifdef VIDEO_ARB_STRICT_PRIORITY_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        chk("contention_grants", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("contention_order", 32'(grant_log[i]), 32'(exp_order[i]));
        chk("contention_wr0", 32'(wr_cnt[0]), 32'd96);
        chk("contention_wr1", 32'(wr_cnt[1]), 32'd96);

        // Backpressure on client 1 for five cycles in the middle of a chunk.
        clear_counts();
        q1.push_back(RB'($urandom));
        n = 0;
        while (!(owner == 1 && !offered && got >= 10) && n < 100) begin
            step(100, 100, 0, 1'b0);
            n++;
        end
        chk("bp_reach", 32'(n < 100), 32'd1);
        repeat (5) step(100, 100, 0, 1'b1);
        n = 0;
        while (owner >= 0 && n < 100) begin
            step(100, 100, 0, 1'b0);
            n++;
        end
        chk("bp_done", 32'(n < 100), 32'd1);
        chk("bp_wr1", 32'(wr_cnt[1]), 32'd32);

        // Randomized traffic, including source strobes in the wrong states.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7) == 0) begin
                if ($urandom_range(1) == 0) begin
                    if (q0.size() < 4) q0.push_back(RB'($urandom));
                end else begin
                    if (q1.size() < 4) q1.push_back(RB'($urandom));
                end
            end
            step(40, 70, 20, 1'b0);
        end

        // Reset in the middle of a client 0 chunk.
        do_reset("pre_midreset");
        q0.delete();
        q1.delete();
        q0.push_back(17'h0AB0A);
        n = 0;
        while (!(owner == 0 && !offered && got == 10) && n < 100) begin
            step(100, 100, 0, 1'b0);
            n++;
        end
        chk("midreset_reach", 32'(n < 100), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        reset_checks("midreset");
        model_reset();
        idle_inputs();
        @(negedge scalerClock);
        reset = 1'b0;
        clear_counts();
        q1.push_back(RB'($urandom));
        q0.push_back(RB'($urandom));
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && owner < 0) && n < 200) begin
            step(100, 100, 0, 1'b0);
            n++;
        end
        chk("post_reset_done", 32'(n < 200), 32'd1);
        chk("post_reset_first", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'hFFFF_FFFF, 32'd0);
        chk("post_reset_wr0", 32'(wr_cnt[0]), 32'd32);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
